// File: rtl/clk_lock_mon_pkg.sv
// Shared state encoding and default parameters for the PLL lock supervisor.
// The FAIL state is only reachable when CLK_LOCK_MON_RETRY_LIMIT_EN is defined.
package clk_lock_mon_pkg;

  typedef enum logic [2:0] {
    StPllRst   = 3'b000,
    StWaitLock = 3'b001,
    StStable   = 3'b010,
    StRun      = 3'b011,
    StFail     = 3'b100
  } lock_state_e;

  localparam int unsigned DefRstPulse   = 10;
  localparam int unsigned DefLockTimeout = 50000;
  localparam int unsigned DefStableCyc  = 1000;
  localparam int unsigned DefCntW       = 8;
  localparam int unsigned DefMaxRetry   = 4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single-bit level crossing into i_clk.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/clk_lock_mon.sv
// PLL lock supervisor: pulses pll_rst, waits for stable lock, then releases user_rst.
// Define CLK_LOCK_MON_RETRY_LIMIT_EN to add MAX_RETRY and a sticky FAIL state.
module clk_lock_mon
  import clk_lock_mon_pkg::*;
#(
  parameter int unsigned RST_PULSE    = DefRstPulse,
  parameter int unsigned LOCK_TIMEOUT = DefLockTimeout,
  parameter int unsigned STABLE_CYC   = DefStableCyc,
  parameter int unsigned CNT_W        = DefCntW
`ifdef CLK_LOCK_MON_RETRY_LIMIT_EN
  ,
  parameter int unsigned MAX_RETRY    = DefMaxRetry
`endif
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             locked,
  input  logic             clr_stat,
  output logic             pll_rst,
  output logic             user_rst,
  output logic             clk_ok,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] retry_cnt,
  output logic             err_fail
);

  localparam int unsigned TmrMax = max3(RST_PULSE, LOCK_TIMEOUT, STABLE_CYC);
  localparam int unsigned TMR_W  = $clog2(TmrMax) + 1;

  localparam logic [TMR_W-1:0] TmrOne  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TmrRst  = TMR_W'(RST_PULSE);
  localparam logic [TMR_W-1:0] TmrLock = TMR_W'(LOCK_TIMEOUT);
  // The WAIT_LOCK->STABLE edge already counts as the first locked cycle.
  localparam logic [TMR_W-1:0] TmrStb  = TMR_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  logic w_lock_s;

  sync_2ff u_sync (
    .i_clk (sys_clk),
    .i_rst (sys_rst),
    .i_d   (locked),
    .o_q   (w_lock_s)
  );

  lock_state_e      r_state;
  lock_state_e      w_state_d;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_d;
  logic             w_loss_inc;
  logic             w_retry_inc;
  logic             w_retry_last;

  logic [CNT_W-1:0] r_loss_cnt;
  logic [CNT_W-1:0] w_loss_cnt_d;
  logic [CNT_W-1:0] r_retry_cnt;
  logic [CNT_W-1:0] w_retry_cnt_d;

  logic r_pll_rst;
  logic r_user_rst;
  logic r_clk_ok;
  logic w_pll_rst_d;
  logic w_user_rst_d;
  logic w_clk_ok_d;

  always_comb begin
    w_state_d   = r_state;
    w_tmr_d     = r_tmr;
    w_loss_inc  = 1'b0;
    w_retry_inc = 1'b0;
    case (r_state)
      StPllRst: begin
        if (r_tmr <= TmrOne) begin
          w_state_d = StWaitLock;
          w_tmr_d   = TmrLock;
        end else begin
          w_tmr_d = r_tmr - TmrOne;
        end
      end
      StWaitLock: begin
        // Lock takes priority over a timeout expiring on the same cycle.
        if (w_lock_s) begin
          if (STABLE_CYC <= 1) begin
            w_state_d = StRun;
          end else begin
            w_state_d = StStable;
            w_tmr_d   = TmrStb;
          end
        end else if (r_tmr <= TmrOne) begin
          w_retry_inc = 1'b1;
          if (w_retry_last) begin
            w_state_d = StFail;
          end else begin
            w_state_d = StPllRst;
            w_tmr_d   = TmrRst;
          end
        end else begin
          w_tmr_d = r_tmr - TmrOne;
        end
      end
      StStable: begin
        if (!w_lock_s) begin
          w_state_d = StWaitLock;
          w_tmr_d   = TmrLock;
        end else if (r_tmr <= TmrOne) begin
          w_state_d = StRun;
        end else begin
          w_tmr_d = r_tmr - TmrOne;
        end
      end
      StRun: begin
        // The wizard relocks by itself, so a loss goes straight back to waiting.
        if (!w_lock_s) begin
          w_loss_inc = 1'b1;
          w_state_d  = StWaitLock;
          w_tmr_d    = TmrLock;
        end
      end
`ifdef CLK_LOCK_MON_RETRY_LIMIT_EN
      StFail: begin
        w_state_d = StFail;
      end
`endif
      default: begin
        w_state_d = StPllRst;
        w_tmr_d   = TmrRst;
      end
    endcase
  end

  always_comb begin
    w_pll_rst_d  = (w_state_d == StPllRst) || (w_state_d == StFail);
    w_user_rst_d = (w_state_d != StRun);
    w_clk_ok_d   = (w_state_d == StRun);

    if (clr_stat) begin
      w_loss_cnt_d  = '0;
      w_retry_cnt_d = '0;
    end else begin
      w_loss_cnt_d  = (w_loss_inc && (r_loss_cnt != CntMax)) ? r_loss_cnt + 1'b1 : r_loss_cnt;
      w_retry_cnt_d = (w_retry_inc && (r_retry_cnt != CntMax)) ? r_retry_cnt + 1'b1
                                                                : r_retry_cnt;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= StPllRst;
      r_tmr       <= TmrRst;
      r_pll_rst   <= 1'b1;
      r_user_rst  <= 1'b1;
      r_clk_ok    <= 1'b0;
      r_loss_cnt  <= '0;
      r_retry_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_tmr       <= w_tmr_d;
      r_pll_rst   <= w_pll_rst_d;
      r_user_rst  <= w_user_rst_d;
      r_clk_ok    <= w_clk_ok_d;
      r_loss_cnt  <= w_loss_cnt_d;
      r_retry_cnt <= w_retry_cnt_d;
    end
  end

`ifdef CLK_LOCK_MON_RETRY_LIMIT_EN
  localparam int unsigned CONS_W = $clog2(MAX_RETRY + 1);

  logic [CONS_W-1:0] r_consec;
  logic              r_err_fail;

  assign w_retry_last = ((32'(r_consec) + 32'd1) >= MAX_RETRY);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_consec   <= '0;
      r_err_fail <= 1'b0;
    end else begin
      if (w_state_d == StRun) begin
        r_consec <= '0;
      end else if (w_retry_inc) begin
        r_consec <= r_consec + 1'b1;
      end
      r_err_fail <= (w_state_d == StFail);
    end
  end

  assign err_fail = r_err_fail;
`else
  assign w_retry_last = 1'b0;
  assign err_fail     = 1'b0;
`endif

  assign pll_rst       = r_pll_rst;
  assign user_rst      = r_user_rst;
  assign clk_ok        = r_clk_ok;
  assign lock_loss_cnt = r_loss_cnt;
  assign retry_cnt     = r_retry_cnt;

endmodule
